// File: rtl/control_pkg.sv
// ============================================================================
// Module      : control_pkg
// Description : Shared definitions for the multicycle control unit: FSM state
//               encoding, supported RV32 opcodes, immediate-type codes, ALU
//               operation codes and ALU operand-select codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package control_pkg;

    // Encoding is visible on the debug port, so the values are fixed
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAMPA = 3'd5
    } estado_t;

    // Supported opcodes
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;

    // Immediate types for the immediate generator
    localparam logic [2:0] c_IMM_I = 3'd0;
    localparam logic [2:0] c_IMM_S = 3'd1;
    localparam logic [2:0] c_IMM_B = 3'd2;
    localparam logic [2:0] c_IMM_U = 3'd3;
    localparam logic [2:0] c_IMM_J = 3'd4;

    // ALU operations
    localparam logic [1:0] c_ALU_ADD   = 2'd0;
    localparam logic [1:0] c_ALU_SUB   = 2'd1;
    localparam logic [1:0] c_ALU_FUNCT = 2'd2;

    // ALU operand selects
    localparam logic [1:0] c_SRCA_PC     = 2'd0;
    localparam logic [1:0] c_SRCA_RS1    = 2'd1;
    localparam logic [1:0] c_SRCA_ZERO   = 2'd2;
    localparam logic [1:0] c_SRCB_RS2    = 2'd0;
    localparam logic [1:0] c_SRCB_IMM    = 2'd1;
    localparam logic [1:0] c_SRCB_CUATRO = 2'd2;

    // Branch funct3 values handled by the unit
    localparam logic [2:0] c_F3_BEQ = 3'b000;
    localparam logic [2:0] c_F3_BNE = 3'b001;

endpackage : control_pkg

`default_nettype wire

// File: rtl/decodificador_imm_sel.sv
// ============================================================================
// Module      : decodificador_imm_sel
// Description : Combinational opcode decoder. Maps an opcode to the immediate
//               type and flags whether the opcode is supported.
// Ports       : i_opcode  [6:0] instruction opcode
//               o_imm_sel [2:0] immediate type (I/S/B/U/J)
//               o_legal         1 when the opcode is supported
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decodificador_imm_sel
    import control_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic [2:0] o_imm_sel,
    output logic       o_legal
);

    always_comb begin
        o_imm_sel = c_IMM_I;
        o_legal   = 1'b1;
        case (i_opcode)
            c_OPC_LOAD:   o_imm_sel = c_IMM_I;
            c_OPC_OPIMM:  o_imm_sel = c_IMM_I;
            c_OPC_OP:     o_imm_sel = c_IMM_I;  // no immediate; value irrelevant
            c_OPC_STORE:  o_imm_sel = c_IMM_S;
            c_OPC_BRANCH: o_imm_sel = c_IMM_B;
            c_OPC_LUI:    o_imm_sel = c_IMM_U;
            c_OPC_JAL:    o_imm_sel = c_IMM_J;
            default:      o_legal   = 1'b0;
        endcase
    end

endmodule : decodificador_imm_sel

`default_nettype wire

// File: rtl/unidad_control_multiciclo.sv
// ============================================================================
// Module      : unidad_control_multiciclo
// Description : Multicycle RV32 subset control FSM
//               (FETCH/DECODE/EXEC/MEM/WB/TRAMPA). Drives datapath strobes and
//               operand selects; unsupported instructions park in TRAMPA
//               until reset.
// Ports       : clk, reset_n (async, active low)
//               opcode[6:0], funct3[2:0]  instruction fields
//               instr_valida, mem_listo   memory handshakes
//               cero                      ALU zero flag (used in EXEC)
//               pc_write, ir_write, mem_read, mem_write, reg_write,
//               mem_to_reg, trampa        strobes / flags
//               imm_sel[2:0], alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0]
//               estado[2:0]               current state (debug)
// Config      : CONTADOR_INSTR_EN - adds output instr_retiradas[31:0], a
//               wrapping count of instructions retired to FETCH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unidad_control_multiciclo
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       instr_valida,
    input  logic       mem_listo,
    input  logic       cero,
    output logic       pc_write,
    output logic       ir_write,
    output logic [2:0] imm_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       trampa,
    output logic [2:0] estado
`ifdef CONTADOR_INSTR_EN
    ,
    output logic [31:0] instr_retiradas
`endif
);

    estado_t    r_estado;
    estado_t    w_estado_sig;
    logic [6:0] r_opcode;

    logic [6:0] w_opcode_dec;
    logic [2:0] w_imm_dec;
    logic       w_legal;
    logic       w_salto;

    logic       w_pc_write;
    logic       w_ir_write;
    logic [2:0] w_imm_sel;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_mem_to_reg;
    logic       w_trampa;

    // In DECODE the opcode has not been captured yet, so decode the live bus;
    // afterwards use the captured copy.
    assign w_opcode_dec = (r_estado == S_DECODE) ? opcode : r_opcode;

    decodificador_imm_sel u_dec (
        .i_opcode  (w_opcode_dec),
        .o_imm_sel (w_imm_dec),
        .o_legal   (w_legal)
    );

    assign w_salto = ((funct3 == c_F3_BEQ) &&  cero) ||
                     ((funct3 == c_F3_BNE) && !cero);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= S_FETCH;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Opcode capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_opcode <= '0;
        end else if (r_estado == S_DECODE) begin
            r_opcode <= opcode;
        end
    end

    // Next state and outputs
    always_comb begin
        w_estado_sig = r_estado;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_imm_sel    = c_IMM_I;
        w_alu_src_a  = c_SRCA_PC;
        w_alu_src_b  = c_SRCB_RS2;
        w_alu_op     = c_ALU_ADD;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_trampa     = 1'b0;

        case (r_estado)
            S_FETCH: begin
                // PC + 4 computed while the instruction is read
                w_mem_read  = 1'b1;
                w_alu_src_b = c_SRCB_CUATRO;
                if (instr_valida) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_estado_sig = S_DECODE;
                end
            end

            S_DECODE: begin
                w_imm_sel    = w_imm_dec;
                w_estado_sig = w_legal ? S_EXEC : S_TRAMPA;
            end

            S_EXEC: begin
                w_imm_sel   = w_imm_dec;
                w_alu_src_a = c_SRCA_RS1;
                case (r_opcode)
                    c_OPC_OP: begin
                        w_alu_op     = c_ALU_FUNCT;
                        w_estado_sig = S_WB;
                    end
                    c_OPC_OPIMM: begin
                        w_alu_op     = c_ALU_FUNCT;
                        w_alu_src_b  = c_SRCB_IMM;
                        w_estado_sig = S_WB;
                    end
                    c_OPC_LOAD, c_OPC_STORE: begin
                        w_alu_src_b  = c_SRCB_IMM;
                        w_estado_sig = S_MEM;
                    end
                    c_OPC_LUI: begin
                        w_alu_src_a  = c_SRCA_ZERO;
                        w_alu_src_b  = c_SRCB_IMM;
                        w_estado_sig = S_WB;
                    end
                    c_OPC_BRANCH: begin
                        w_alu_op = c_ALU_SUB;
                        if ((funct3 == c_F3_BEQ) || (funct3 == c_F3_BNE)) begin
                            w_pc_write   = w_salto;
                            w_estado_sig = S_FETCH;
                        end else begin
                            w_estado_sig = S_TRAMPA;
                        end
                    end
                    c_OPC_JAL: begin
                        // Jump target PC + imm; link written in the same cycle
                        w_alu_src_a  = c_SRCA_PC;
                        w_alu_src_b  = c_SRCB_IMM;
                        w_pc_write   = 1'b1;
                        w_reg_write  = 1'b1;
                        w_estado_sig = S_FETCH;
                    end
                    default: w_estado_sig = S_TRAMPA;
                endcase
            end

            S_MEM: begin
                // Keep the address computation stable for the whole access
                w_imm_sel   = w_imm_dec;
                w_alu_src_a = c_SRCA_RS1;
                w_alu_src_b = c_SRCB_IMM;
                if (r_opcode == c_OPC_STORE) begin
                    w_mem_write = 1'b1;
                end else begin
                    w_mem_read  = 1'b1;
                end
                if (mem_listo) begin
                    w_estado_sig = (r_opcode == c_OPC_LOAD) ? S_WB : S_FETCH;
                end
            end

            S_WB: begin
                w_imm_sel    = w_imm_dec;
                w_reg_write  = 1'b1;
                w_mem_to_reg = (r_opcode == c_OPC_LOAD);
                w_estado_sig = S_FETCH;
            end

            S_TRAMPA: begin
                w_trampa = 1'b1;
            end

            default: w_estado_sig = S_FETCH;
        endcase
    end

    // While reset is held the FSM sits in FETCH, whose decode would raise
    // mem_read; all outputs are forced to zero for the whole reset window.
    assign pc_write   = reset_n & w_pc_write;
    assign ir_write   = reset_n & w_ir_write;
    assign mem_read   = reset_n & w_mem_read;
    assign mem_write  = reset_n & w_mem_write;
    assign reg_write  = reset_n & w_reg_write;
    assign mem_to_reg = reset_n & w_mem_to_reg;
    assign trampa     = reset_n & w_trampa;
    assign imm_sel    = reset_n ? w_imm_sel   : 3'd0;
    assign alu_src_a  = reset_n ? w_alu_src_a : 2'd0;
    assign alu_src_b  = reset_n ? w_alu_src_b : 2'd0;
    assign alu_op     = reset_n ? w_alu_op    : 2'd0;
    assign estado     = r_estado;

`ifdef CONTADOR_INSTR_EN
    logic [31:0] r_instr_retiradas;
    logic        w_retira;

    // Retirement = completing EXEC/MEM/WB back to FETCH (never via TRAMPA)
    assign w_retira = (w_estado_sig == S_FETCH) &&
                      ((r_estado == S_EXEC) || (r_estado == S_MEM) ||
                       (r_estado == S_WB));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instr_retiradas <= '0;
        end else if (w_retira) begin
            r_instr_retiradas <= r_instr_retiradas + 32'd1;
        end
    end

    assign instr_retiradas = r_instr_retiradas;
`endif

endmodule : unidad_control_multiciclo

`default_nettype wire

// File: doc/unidad_control_multiciclo.md
UNIDAD_CONTROL_MULTICICLO -- requirements
Module: unidad_control_multiciclo

Interface
REQ-001 Signals SHALL be: clk, reset_n, opcode, funct3, instr_valida, mem_listo, cero, pc_write, ir_write, imm_sel, alu_src_a, alu_src_b, alu_op, mem_read, mem_write, reg_write, mem_to_reg, trampa, estado.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  7  instruction bits [6:0], stable from DECODE until return to FETCH.
REQ-005 funct3  in  3  instruction bits [14:12], same stability.
REQ-006 instr_valida  in  1  instruction memory data valid.
REQ-007 mem_listo  in  1  data memory access complete.
REQ-008 cero  in  1  ALU zero flag, sampled in EXEC.
REQ-009 pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, trampa  out  1 each  datapath strobes/flags.
REQ-010 imm_sel  out  3  immediate type to immediate generator: I=0, S=1, B=2, U=3, J=4.
REQ-011 alu_src_a  out  2  0=PC, 1=rs1, 2=zero; alu_src_b out 2: 0=rs2, 1=imm, 2=const 4.
REQ-012 alu_op  out  2  0=add, 1=sub/compare, 2=funct-decoded.
REQ-013 estado  out  3  current state encoding for debug.

Function
REQ-014 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAMPA=5; outputs SHALL be Moore-decoded from state, latched opcode and cero.
REQ-015 FETCH: mem_read=1, alu_src_a=0, alu_src_b=2; stay while instr_valida=0; on instr_valida=1 assert ir_write=1 and pc_write=1 that cycle, go DECODE.
REQ-016 DECODE: latch opcode; imm_sel from opcode (LOAD/OP-IMM->I, STORE->S, BRANCH->B, LUI->U, JAL->J, OP->I don't-care); unsupported opcode -> TRAMPA, else EXEC.
REQ-017 Supported opcodes SHALL be LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011, BRANCH 1100011, JAL 1101111, LUI 0110111.
REQ-018 EXEC: OP/OP-IMM -> WB with alu_op=2; LOAD/STORE -> MEM with alu_op=0, alu_src_b=1; LUI -> WB with alu_src_a=2, alu_src_b=1.
REQ-019 EXEC BRANCH: alu_op=1; pc_write=1 iff (funct3=000 and cero=1) or (funct3=001 and cero=0); other funct3 -> TRAMPA; then FETCH.
REQ-020 EXEC JAL: pc_write=1 and reg_write=1 same cycle, then FETCH.
REQ-021 MEM: mem_read (LOAD) or mem_write (STORE) held until mem_listo=1; then LOAD -> WB, STORE -> FETCH.
REQ-022 WB: reg_write=1 for exactly one cycle; mem_to_reg=1 only for LOAD; then FETCH.
REQ-023 TRAMPA: trampa=1, all strobes 0, remains until reset.
REQ-024 Minimum latency: OP 4 cycles, LOAD 5 cycles, BRANCH/JAL 3 cycles (zero wait states).
REQ-025 Strobes outside their listed states SHALL be 0; no two of mem_read/mem_write high simultaneously.

Reset
REQ-026 reset_n=0 SHALL immediately force state FETCH, clear latched opcode, counter and trampa, regardless of state or pending handshake.
REQ-027 Reset values: all strobes 0, imm_sel 0, alu selects 0, estado 0.

Configuration
REQ-028 Macro CONTADOR_INSTR_EN SHALL, when defined, add output instr_retiradas (32 bits) incrementing by 1 on each transition into FETCH from EXEC, MEM or WB, wrapping at 2^32; undefined: port and counter absent, all other behaviour identical.

Structure
REQ-029 Package control_pkg SHALL hold state enum, opcode constants, imm_sel and alu_op encodings.
REQ-030 Sub-module decodificador_imm_sel SHALL map opcode to imm_sel and legality combinationally.

Verification
REQ-031 OP add, instr_valida after 2 wait cycles -> ir_write at cycle 3, reg_write in WB, back in FETCH after 6 cycles.
REQ-032 LOAD opcode 0000011, mem_listo after 3 cycles -> imm_sel=0, mem_read held 3 cycles, mem_to_reg=1 with reg_write.
REQ-033 BRANCH funct3=000: cero=1 -> pc_write in EXEC, imm_sel=2; cero=0 -> no pc_write.
REQ-034 opcode 1111111 -> TRAMPA, trampa=1 persists 10 cycles; reset_n pulse -> FETCH, trampa=0.
REQ-035 reset_n asserted mid-MEM of STORE -> mem_write drops asynchronously, estado=0.
REQ-036 CONTADOR_INSTR_EN defined, 5 instructions retired -> instr_retiradas=5; preload 32'hFFFFFFFF -> wraps to 0.
